// File: rtl/cache_line_mover.sv
// Line refill / writeback burst engine for one cache way: 8-beat memory bursts <-> single-cycle data array write.
// Optional build macro LINE_MOVER_PERF_EN adds refill/writeback/stall performance counters.
module cache_line_mover #(
    parameter int LINE_WIDTH     = 256,
    parameter int BEAT_WIDTH     = 32,
    parameter int SET_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [31:0]               cmd_addr,
    input  logic [SET_ADDR_WIDTH-1:0] cmd_set,
    input  logic [LINE_WIDTH-1:0]     cmd_line,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_wen,
    output logic [31:0]               mem_req_addr,
    output logic [BEAT_WIDTH-1:0]     mem_wdata,
    output logic                      mem_wvalid,
    output logic                      mem_wlast,
    input  logic                      mem_wready,
    input  logic [BEAT_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_rvalid,
    input  logic                      mem_rlast,
    output logic                      mem_rready,
    output logic                      da_wen,
    output logic [SET_ADDR_WIDTH-1:0] da_waddr,
    output logic [LINE_WIDTH-1:0]     da_wdata,
    output logic                      done,
    output logic                      err,
`ifdef LINE_MOVER_PERF_EN
    output logic [31:0]               perf_refills,
    output logic [31:0]               perf_writebacks,
    output logic [31:0]               perf_stall_cycles,
`endif
    output logic [2:0]                dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WBEAT = 3'd2,
        ST_RBEAT = 3'd3,
        ST_FILL  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t                    state, state_nx;
    logic                      is_write;
    logic [31:0]               addr_q;
    logic [SET_ADDR_WIDTH-1:0] set_q;
    logic [LINE_WIDTH-1:0]     line_q;
    logic [2:0]                cnt;
    logic                      err_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            is_write <= 1'b0;
            addr_q   <= '0;
            set_q    <= '0;
            line_q   <= '0;
            cnt      <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        is_write <= cmd_write;
                        addr_q   <= cmd_addr & 32'hFFFF_FFE0;
                        set_q    <= cmd_set;
                        line_q   <= cmd_line;
                        cnt      <= '0;
                    end
                end
                ST_WBEAT: begin
                    if (mem_wready) begin
                        line_q <= {{BEAT_WIDTH{1'b0}}, line_q[LINE_WIDTH-1:BEAT_WIDTH]};
                        cnt    <= cnt + 3'd1;
                    end
                end
                ST_RBEAT: begin
                    // Beats shift in from the top, so after eight beats beat k sits at word k.
                    if (mem_rvalid) begin
                        line_q <= {mem_rdata, line_q[LINE_WIDTH-1:BEAT_WIDTH]};
                        cnt    <= cnt + 3'd1;
                        if (mem_rlast != (cnt == 3'd7)) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx      = state;
        cmd_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_wen   = 1'b0;
        mem_req_addr  = '0;
        mem_wvalid    = 1'b0;
        mem_wdata     = '0;
        mem_wlast     = 1'b0;
        mem_rready    = 1'b0;
        da_wen        = 1'b0;
        da_waddr      = '0;
        da_wdata      = '0;
        done          = 1'b0;
        err           = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_wen   = is_write;
                mem_req_addr  = addr_q;
                if (mem_req_ready) state_nx = is_write ? ST_WBEAT : ST_RBEAT;
            end
            ST_WBEAT: begin
                mem_wvalid = 1'b1;
                mem_wdata  = line_q[BEAT_WIDTH-1:0];
                mem_wlast  = (cnt == 3'd7);
                if (mem_wready && cnt == 3'd7) state_nx = ST_DONE;
            end
            ST_RBEAT: begin
                mem_rready = 1'b1;
                // An early rlast abandons the line: the data array is left untouched.
                if (mem_rvalid) begin
                    if (mem_rlast && cnt != 3'd7) state_nx = ST_DONE;
                    else if (cnt == 3'd7)         state_nx = ST_FILL;
                end
            end
            ST_FILL: begin
                da_wen   = 1'b1;
                da_waddr = set_q;
                da_wdata = line_q;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                err      = err_q;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign dbg_state = state;

`ifdef LINE_MOVER_PERF_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_refills      <= '0;
            perf_writebacks   <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (state == ST_DONE && !is_write) perf_refills    <= perf_refills + 32'd1;
            if (state == ST_DONE &&  is_write) perf_writebacks <= perf_writebacks + 32'd1;
            if ((state == ST_REQ   && !mem_req_ready) ||
                (state == ST_WBEAT && !mem_wready)    ||
                (state == ST_RBEAT && !mem_rvalid)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_line_mover.sv
// Randomized scoreboard bench for cache_line_mover: drivers push expected transfers, a negedge monitor pops and compares.
module tb_cache_line_mover;
  localparam int LW = 256;
  localparam int BW = 32;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [SW-1:0] cmd_set = '0;
  logic [LW-1:0] cmd_line = '0;
  logic mem_req_valid;
  logic mem_req_ready = 1'b0;
  logic mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [BW-1:0] mem_wdata;
  logic mem_wvalid;
  logic mem_wlast;
  logic mem_wready = 1'b0;
  logic [BW-1:0] mem_rdata = '0;
  logic mem_rvalid = 1'b0;
  logic mem_rlast = 1'b0;
  logic mem_rready;
  logic da_wen;
  logic [SW-1:0] da_waddr;
  logic [LW-1:0] da_wdata;
  logic done;
  logic err;
  logic [2:0] dbg_state;
`ifdef LINE_MOVER_PERF_EN
  logic [31:0] perf_refills;
  logic [31:0] perf_writebacks;
  logic [31:0] perf_stall_cycles;
`endif

  cache_line_mover dut (
    .clk(clk),
    .resetn(resetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_set(cmd_set),
    .cmd_line(cmd_line),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr),
    .mem_wdata(mem_wdata),
    .mem_wvalid(mem_wvalid),
    .mem_wlast(mem_wlast),
    .mem_wready(mem_wready),
    .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid),
    .mem_rlast(mem_rlast),
    .mem_rready(mem_rready),
    .da_wen(da_wen),
    .da_waddr(da_waddr),
    .da_wdata(da_wdata),
    .done(done),
    .err(err),
`ifdef LINE_MOVER_PERF_EN
    .perf_refills(perf_refills),
    .perf_writebacks(perf_writebacks),
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int checks = 0;
  int failures = 0;
  logic [32:0]    exp_req_q[$];   // {wen, addr}
  logic [32:0]    exp_w_q[$];     // {last, data}
  logic [SW+LW-1:0] exp_da_q[$];  // {set, line}
  logic [0:0]     exp_done_q[$];  // err flag
  int             exp_lat_q[$];   // accept-to-done cycles, -1 = unchecked
  int accept_cyc = 0;
  int last_done_cyc = -100;
  bit busy_flag = 1'b0;
  bit expect_b2b = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s act=unexpected_event exp=none", name);
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL timeout_%s act=no_handshake exp=handshake", name);
  endtask

  // monitor
  always @(negedge clk) begin : monitor
    int lat;
    if (resetn) begin
      if (busy_flag) check("cmd_ready_busy", 512'(cmd_ready), 512'(0));
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req_q.size() == 0) unexpected("req");
        else check("req_wen_addr", 512'({mem_req_wen, mem_req_addr}), 512'(exp_req_q.pop_front()));
      end
      if (mem_wvalid && mem_wready) begin
        if (exp_w_q.size() == 0) unexpected("wbeat");
        else check("wbeat_last_data", 512'({mem_wlast, mem_wdata}), 512'(exp_w_q.pop_front()));
      end
      if (da_wen) begin
        if (exp_da_q.size() == 0) unexpected("da_wen");
        else check("da_set_line", 512'({da_waddr, da_wdata}), 512'(exp_da_q.pop_front()));
      end
      if (done) begin
        if (exp_done_q.size() == 0) unexpected("done");
        else begin
          check("done_err", 512'(err), 512'(exp_done_q.pop_front()));
          lat = exp_lat_q.pop_front();
          if (lat >= 0) check("done_latency", 512'(cyc - accept_cyc), 512'(lat));
        end
        last_done_cyc = cyc;
        busy_flag = 1'b0;
      end else if (err) begin
        unexpected("err_without_done");
      end
    end
  end

  // driver tasks
  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [SW-1:0] set,
                           input logic [LW-1:0] line, input bit hold, output bit ok);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_set   = set;
    cmd_line  = line;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        accept_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    if (!ok) timeout("cmd_accept");
    busy_flag = ok;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic mem_req(input int delay, output bit ok);
    mem_req_ready = 1'b0;
    if (delay > 0) begin
      // traffic on the beat channels while not in a beat phase must be ignored
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      mem_rlast  = 1'($urandom_range(0, 1));
      mem_wready = 1'b1;
    end
    repeat (delay) begin
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = mem_req_valid;
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    mem_wready = 1'b0;
    if (!ok) timeout("mem_req");
  endtask

  task automatic mem_read(input logic [LW-1:0] beats, input int rlast_idx, input int n, input int gap_max);
    bit hs;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, gap_max)) begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = beats[k*BW +: BW];
      mem_rlast  = (k == rlast_idx);
      hs = 1'b0;
      for (int i = 0; i < 200 && !hs; i++) begin
        @(negedge clk);
        hs = mem_rready;
        @(posedge clk); #1;
      end
      if (!hs) timeout("rbeat");
      mem_rvalid = 1'b0;
      mem_rlast  = 1'b0;
    end
  endtask

  // mode 0: always ready, 1: toggling, 2: random
  task automatic mem_write(input int mode);
    int got = 0;
    bit tog = 1'b0;
    for (int i = 0; i < 400 && got < 8; i++) begin
      mem_wready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      @(negedge clk);
      if (mem_wvalid && mem_wready) got++;
      @(posedge clk); #1;
    end
    mem_wready = 1'b0;
    if (got < 8) timeout("wbeat");
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = done;
      @(posedge clk); #1;
    end
    if (!seen) timeout("done");
  endtask

  // reference model: data is the victim line (writeback) or the beat sequence, beat k = word k (refill)
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [SW-1:0] set,
                         input logic [LW-1:0] data, input int req_delay, input int mode,
                         input int rlast_idx, input int lat, input bit hold);
    bit ok;
    int n;
    exp_req_q.push_back({wr, addr & 32'hFFFF_FFE0});
    if (wr) begin
      for (int k = 0; k < 8; k++) exp_w_q.push_back({k == 7, data[k*BW +: BW]});
      exp_done_q.push_back(1'b0);
    end else begin
      if (rlast_idx >= 7) exp_da_q.push_back({set, data});
      exp_done_q.push_back(rlast_idx != 7);
    end
    exp_lat_q.push_back(lat);
    issue_cmd(wr, addr, set, wr ? data : ~data, hold, ok);
    if (!ok) return;
    if (expect_b2b) begin
      check("b2b_accept_cycle", 512'(accept_cyc), 512'(last_done_cyc + 1));
      expect_b2b = 1'b0;
    end
    mem_req(req_delay, ok);
    if (!ok) return;
    n = (rlast_idx < 7) ? rlast_idx + 1 : 8;
    if (wr) mem_write(mode);
    else    mem_read(data, rlast_idx, n, mode);
    wait_done();
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_cmd_ready"}, 512'(cmd_ready), 512'(1));
    check({name, "_ctrl_outs"}, 512'({mem_req_valid, mem_req_wen, mem_req_addr, mem_wvalid, mem_wlast,
                                      mem_wdata, mem_rready, da_wen, da_waddr, done, err}), 512'(0));
    check({name, "_da_wdata"}, 512'(da_wdata), 512'(0));
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < 8; k++) l[k*BW +: BW] = $urandom;
    return l;
  endfunction

  // stimulus
  initial begin
    logic [LW-1:0] l;
    int r, idx;
    bit ok;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;

`ifdef LINE_MOVER_PERF_EN
    run_cmd(1'b0, 32'h0000_0100, 8'h01, rand_line(), 3, 0, 7, -1, 1'b0);
    run_cmd(1'b1, 32'h0000_0200, 8'h02, rand_line(), 3, 0, 7, -1, 1'b0);
    run_cmd(1'b0, 32'h0000_0300, 8'h03, rand_line(), 3, 0, 7, -1, 1'b0);
    @(negedge clk);
    check("perf_refills", 512'(perf_refills), 512'(2));
    check("perf_writebacks", 512'(perf_writebacks), 512'(1));
    check("perf_stall_cycles", 512'(perf_stall_cycles), 512'(9));
    @(posedge clk); #1;
`endif

    // refill, no stalls, beats 0..7
    for (int k = 0; k < 8; k++) l[k*BW +: BW] = k;
    run_cmd(1'b0, 32'h1000_0014, 8'h2A, l, 0, 0, 7, 11, 1'b0);

    // writeback with toggling wready, then a zero-stall writeback for latency
    for (int k = 0; k < 8; k++) l[k*BW +: BW] = 32'hA000_0000 + k;
    run_cmd(1'b1, 32'h2000_003F, 8'h11, l, 0, 1, 7, -1, 1'b0);
    run_cmd(1'b1, 32'h3000_0040, 8'h12, rand_line(), 0, 0, 7, 10, 1'b0);

    // early rlast on beat 3, then next command back to back
    run_cmd(1'b0, 32'h4000_0080, 8'h33, rand_line(), 0, 0, 3, -1, 1'b0);
    expect_b2b = 1'b1;
    run_cmd(1'b0, 32'h4000_00A0, 8'h34, rand_line(), 0, 0, 7, 11, 1'b0);

    // rlast missing on the last beat: line still filled, err flagged
    run_cmd(1'b0, 32'h5000_0000, 8'h35, rand_line(), 1, 1, 8, -1, 1'b0);

    // cmd_valid held through a busy refill
    run_cmd(1'b0, 32'h6000_0000, 8'h40, rand_line(), 0, 0, 7, 11, 1'b1);
    expect_b2b = 1'b1;
    run_cmd(1'b1, 32'h6000_0020, 8'h41, rand_line(), 0, 0, 7, 10, 1'b0);

    // reset pulse during beat 5 of a refill
    l = rand_line();
    exp_req_q.push_back({1'b0, 32'h7000_0000});
    issue_cmd(1'b0, 32'h7000_0010, 8'h50, ~l, 1'b0, ok);
    mem_req(0, ok);
    mem_read(l, 8, 5, 0);
    resetn = 1'b0;
    busy_flag = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = l[5*BW +: BW];
    @(posedge clk); #1;
    resetn = 1'b1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_burst_reset");
    repeat (15) @(posedge clk);
    #1;
    run_cmd(1'b0, 32'h7000_0040, 8'h51, rand_line(), 0, 0, 7, 11, 1'b0);

    // randomized commands
    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 7);
      idx = (r == 0) ? $urandom_range(0, 6) : (r == 1) ? 8 : 7;
      if ($urandom_range(0, 1) == 1)
        run_cmd(1'b1, $urandom, SW'($urandom), rand_line(), $urandom_range(0, 3), $urandom_range(0, 2), 7, -1, 1'b0);
      else
        run_cmd(1'b0, $urandom, SW'($urandom), rand_line(), $urandom_range(0, 3), $urandom_range(0, 2), idx, -1, 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("left_req", 512'(exp_req_q.size()), 512'(0));
    check("left_wbeat", 512'(exp_w_q.size()), 512'(0));
    check("left_da", 512'(exp_da_q.size()), 512'(0));
    check("left_done", 512'(exp_done_q.size()), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    checks++;
    failures++;
    $display("FAIL watchdog act=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_line_mover.md
# cache_line_mover

Burst engine between the cache controller and main memory for one cache way. Refills a 256-bit line from memory as eight 32-bit beats and writes it into the way's data array in one write-port cycle. Serializes a victim line read from the data array into an eight-beat memory write burst for writeback. Handles one command at a time.

## Interface
- `LINE_WIDTH`, 256: cache line bits; fixed at 8 × `BEAT_WIDTH`.
- `BEAT_WIDTH`, 32: memory data beat bits.
- `SET_ADDR_WIDTH`, 8: data array set index width.
- `clk` in 1: clock; all logic on posedge.
- `resetn` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: controller command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_write` in 1: 1 = writeback, 0 = refill.
- `cmd_addr` in 32: line address; bits [4:0] ignored and driven as 0 to memory.
- `cmd_set` in SET_ADDR_WIDTH: data array set for refill.
- `cmd_line` in LINE_WIDTH: victim line for writeback, sampled at command accept.
- `mem_req_valid` out 1 / `mem_req_ready` in 1: memory request handshake.
- `mem_req_wen` out 1: 1 = write burst.
- `mem_req_addr` out 32: burst base address, line-aligned.
- `mem_wdata` out BEAT_WIDTH, `mem_wvalid` out 1, `mem_wlast` out 1, `mem_wready` in 1: write beat channel.
- `mem_rdata` in BEAT_WIDTH, `mem_rvalid` in 1, `mem_rlast` in 1, `mem_rready` out 1: read beat channel.
- `da_wen` out 1, `da_waddr` out SET_ADDR_WIDTH, `da_wdata` out LINE_WIDTH: data array write port.
- `done` out 1: one-cycle pulse on command completion.
- `err` out 1: one-cycle pulse, together with `done`, on malformed read burst.

## Operation
- States: IDLE, REQ, WBEAT, RBEAT, FILL, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch `cmd_write`, `{cmd_addr[31:5],5'b0}`, `cmd_set`, `cmd_line` into a line shift buffer; clear beat counter (3-bit); go to REQ.
- REQ: `mem_req_valid`=1 with latched address and `mem_req_wen`. On `mem_req_ready`: go to WBEAT if write, else RBEAT.
- WBEAT: `mem_wvalid`=1, `mem_wdata` = buffer[31:0]. On `mem_wready`: shift buffer right 32 bits, increment counter. `mem_wlast`=1 when counter = 7. Handshake with counter = 7 -> DONE.
- RBEAT: `mem_rready`=1. On `mem_rvalid`: beat k placed in buffer bits [32k+31:32k], increment counter. Beat with counter = 7 -> FILL. `mem_rlast` at counter < 7, or counter = 7 without `mem_rlast` -> set error flag; the early-`rlast` case goes straight to DONE without FILL (array untouched); the late case still fills.
- FILL: `da_wen`=1 for exactly one cycle, `da_waddr` = latched set, `da_wdata` = buffer. -> DONE.
- DONE: `done`=1 (plus `err` if flagged), clear flag -> IDLE.
- Beat 0 is always the lowest-addressed word; no critical-word-first.

## Timing
- Reset (`resetn`=0 at posedge): state IDLE; `cmd_ready`=1 after reset; all other outputs 0, buffer/counter/flag cleared. Reset mid-burst abandons the burst immediately with no `da_wen` and no `done`.
- All outputs are registered or decoded purely from state; no combinational path from memory inputs to outputs.
- Refill with zero memory stalls: accept (cycle 0), REQ 1 cycle, 8 RBEAT cycles, FILL 1, DONE 1 -> `done` at cycle 11 after accept.
- Writeback with zero stalls: `done` at cycle 10 after accept.
- Back-to-back: next command accepted the cycle after DONE.
- `mem_rvalid` outside RBEAT is ignored; `mem_wready` outside WBEAT ignored.

## Configuration
- `LINE_MOVER_PERF_EN` defined: adds outputs `perf_refills` (32), `perf_writebacks` (32), `perf_stall_cycles` (32); first two increment at DONE per type, third increments every REQ/WBEAT/RBEAT cycle whose handshake input is low; all reset to 0, wrap at 2^32.
- Undefined: these ports and counters do not exist; behaviour otherwise identical.

## Test plan
- Refill, no stalls, beats 0x00000000..0x00000007, set 0x2A, addr 0x1000_0014 -> `mem_req_addr`=0x1000_0000, one `da_wen` at set 0x2A with `da_wdata`=0x00000007_..._00000000, `done` at cycle 11.
- Writeback of line word k = 0xA000_000k with `mem_wready` toggling every cycle -> eight beats in order 0xA0000000..0xA0000007, `mem_wlast` only on last, no `da_wen`.
- Early `mem_rlast` on beat 3 -> `done`+`err` same cycle, zero `da_wen`, next command accepted.
- `cmd_valid` held high during a busy refill -> `cmd_ready`=0 until after DONE; second command accepted exactly one cycle after `done`.
- `resetn` low for one cycle during beat 5 of refill -> no `da_wen`, no `done`, IDLE with outputs 0; subsequent refill completes correctly.
- With `LINE_MOVER_PERF_EN`: 2 refills + 1 writeback, `mem_req_ready` delayed 3 cycles each -> `perf_refills`=2, `perf_writebacks`=1, `perf_stall_cycles`=9.
